product_accumulator: RTL and testbench

//  Sequential consumer placed directly downstream of the SIZE x SIZE array multiplier.
//  - Accepts one 2*SIZE-bit product per valid/ready handshake.
//  - Sums COUNT consecutive products into a dot-product result.
//  - Presents the result on a registered valid/ready output port and holds it until accepted.

---
 rtl/product_accumulator.sv | 129 ++++++++++++
 tb/tb_product_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Dot-product accumulator fed by the SIZE x SIZE multiplier: sums COUNT products per result.
// Optional MAC_SATURATE_EN: clamp the sum to all-ones on overflow instead of wrapping.
module product_accumulator #(
    parameter int SIZE  = 4,
    parameter int ACC_W = 16,
    parameter int COUNT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SIZE-1:0] in_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    generate
        if (ACC_W < 2 * SIZE) begin : g_bad_acc_w
            $error("product_accumulator: ACC_W must be >= 2*SIZE");
        end
        if (COUNT < 1) begin : g_bad_count
            $error("product_accumulator: COUNT must be >= 1");
        end
    endgenerate

    logic             state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic             busy_q, busy_d;

    logic [ACC_W:0]   p_ext;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] sum_val;
    logic             in_xfer, out_xfer;

    assign in_ready  = (state_q == ST_ACCUM) & ~reset;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = busy_q;

    // One spare bit on the adder captures the carry out of the accumulator MSB.
    assign p_ext   = {{(ACC_W + 1 - 2 * SIZE){1'b0}}, in_p};
    assign sum_ext = {1'b0, acc_q} + p_ext;
    assign carry   = sum_ext[ACC_W];

`ifdef MAC_SATURATE_EN
    // Once clamped, any further nonzero add carries again, so the sum stays at max.
    assign sum_val = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign sum_val = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        busy_d      = busy_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_xfer) begin
                    if (cnt_q == LAST) begin
                        out_sum_d   = sum_val;
                        out_ovf_d   = ovf_q | carry;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d  = sum_val;
                        cnt_d  = cnt_q + CW'(1);
                        ovf_d  = ovf_q | carry;
                        busy_d = 1'b1;
                    end
                end
            end
            default: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: behavioural model + result scoreboard on the main instance,
// directed checks on small-ACC_W and COUNT=1 instances.
module tb_product_accumulator;
    localparam int SIZE = 4, ACC_W = 16, COUNT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // main instance (SIZE=4, ACC_W=16, COUNT=8)
    logic v0 = 0, r0 = 0, rdy0, ov0, ovf0, busy0;
    logic [7:0]  p0 = 0;
    logic [15:0] sum0;
    // ACC_W=8, COUNT=2 instance
    logic v1 = 0, r1 = 1, rdy1, ov1, ovf1, busy1;
    logic [7:0] p1 = 0, sum1;
    // COUNT=1 instance
    logic v2 = 0, r2 = 1, rdy2, ov2, ovf2, busy2;
    logic [7:0]  p2 = 0;
    logic [15:0] sum2;

    product_accumulator #(.SIZE(SIZE), .ACC_W(ACC_W), .COUNT(COUNT)) dut0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_ready(rdy0), .in_p(p0),
        .out_valid(ov0), .out_ready(r0), .out_sum(sum0), .out_ovf(ovf0), .busy(busy0));
    product_accumulator #(.SIZE(4), .ACC_W(8), .COUNT(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1), .in_p(p1),
        .out_valid(ov1), .out_ready(r1), .out_sum(sum1), .out_ovf(ovf1), .busy(busy1));
    product_accumulator #(.SIZE(4), .ACC_W(16), .COUNT(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_p(p2),
        .out_valid(ov2), .out_ready(r2), .out_sum(sum2), .out_ovf(ovf2), .busy(busy2));

    int n_cmp = 0, n_bad = 0, n_hs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Group result from the true (unbounded) sum of its products.
    function automatic longint res(input longint s, input int w);
        longint lim = longint'(1) << w;
`ifdef MAC_SATURATE_EN
        return (s >= lim) ? lim - 1 : s;
`else
        return s % lim;
`endif
    endfunction

    // ---------------- behavioural model of the main instance ----------------
    bit     m_hold = 0, m_ovf = 0;
    int     m_cnt = 0;
    longint m_s = 0, m_sum = 0;
    longint exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_hold = 0; m_cnt = 0; m_s = 0; m_sum = 0; m_ovf = 0;
        end else if (!m_hold) begin
            if (v0) begin
                m_s += p0;
                m_cnt++;
                if (m_cnt == COUNT) begin
                    m_sum  = res(m_s, ACC_W);
                    m_ovf  = (m_s >= (longint'(1) << ACC_W));
                    m_hold = 1; m_cnt = 0; m_s = 0;
                end
            end
        end else if (r0) begin
            m_hold = 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  rdy0,  !reset && !m_hold);
        chk("out_valid", ov0,   m_hold);
        chk("out_sum",   sum0,  m_sum);
        chk("out_ovf",   ovf0,  m_ovf);
        chk("busy",      busy0, m_cnt != 0);
        if (m_hold && r0 && !reset) begin
            chk("result_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("result_sum", sum0, exp_q.pop_front());
            n_hs++;
        end
    end

    // out_ready driver: 0 = always 1, 1 = always 0, 2 = random
    int ordy_mode = 0;
    always begin
        @(posedge clk); #2;
        r0 = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send0(input logic [7:0] p, input bit gaps);
        logic acc;
        if (gaps) while ($urandom_range(1, 0) == 1) cyc();
        v0 = 1; p0 = p;
        for (int t = 0; ; t++) begin
            @(negedge clk); acc = rdy0;
            cyc();
            if (acc) break;
            if (t > 200) begin fail("send_timeout"); break; end
        end
        v0 = 0; p0 = 8'($urandom);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint gs;
        logic [7:0] gp [COUNT];
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // back-to-back 0x0F x 8, out_ready high
        exp_q.push_back(120);
        for (int i = 0; i < 8; i++) send0(8'h0F, 0);
        @(negedge clk);
        chk("t1_valid", ov0, 1); chk("t1_sum", sum0, 16'h0078);
        chk("t1_ovf", ovf0, 0); chk("t1_bubble", rdy0, 0);
        chk("t1_model", m_sum, 'h78);
        cyc();
        @(negedge clk); chk("t1_ready_back", rdy0, 1);
        cyc();

        // 1..8 with result held 5 cycles
        ordy_mode = 1; cyc(); cyc();
        exp_q.push_back(36);
        for (int i = 1; i <= 8; i++) send0(8'(i), 0);
        repeat (5) begin
            @(negedge clk);
            chk("t2_valid", ov0, 1); chk("t2_sum", sum0, 36); chk("t2_ready", rdy0, 0);
        end
        cyc();
        ordy_mode = 0;

        // 3 products, reset mid-group, then 8 x 0x02
        for (int i = 0; i < 3; i++) send0(8'h09, 0);
        reset = 1; cyc(); reset = 0;
        @(negedge clk); chk("t4_busy", busy0, 0); chk("t4_valid", ov0, 0);
        cyc();
        exp_q.push_back(16);
        for (int i = 0; i < 8; i++) send0(8'h02, 0);
        @(negedge clk); chk("t4_valid2", ov0, 1); chk("t4_sum", sum0, 16'h0010);
        cyc();

        // pending result dropped by reset
        ordy_mode = 1; cyc(); cyc();
        for (int i = 0; i < 8; i++) send0(8'h05, 0);
        @(negedge clk); chk("drop_valid", ov0, 1);
        cyc(); reset = 1; cyc(); reset = 0;
        @(negedge clk); chk("drop_gone", ov0, 0); chk("drop_ready", rdy0, 1);
        cyc();

        // random products from random multiplier operands, random gaps
        ordy_mode = 2;
        for (int g = 0; g < 1000; g++) begin
            gs = 0;
            for (int i = 0; i < COUNT; i++) begin
                int x = $urandom_range(15, 0), y = $urandom_range(15, 0);
                gp[i] = 8'(x * y);
                gs += x * y;
            end
            exp_q.push_back(res(gs, ACC_W));
            for (int i = 0; i < COUNT; i++) send0(gp[i], 1);
        end
        ordy_mode = 0;
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) cyc();
        chk("results_left", exp_q.size(), 0);
        chk("handshakes", n_hs, 1003);

        // ACC_W=8, COUNT=2: overflow then clean group
        v1 = 1; p1 = 8'hE1;
        @(negedge clk); chk("t3_rdy_a", rdy1, 1);
        cyc();
        @(negedge clk); chk("t3_busy", busy1, 1); chk("t3_rdy_b", rdy1, 1);
        cyc(); v1 = 0;
        @(negedge clk);
        chk("t3_valid", ov1, 1);
`ifdef MAC_SATURATE_EN
        chk("t3_sum", sum1, 8'hFF);
`else
        chk("t3_sum", sum1, 8'hC2);
`endif
        chk("t3_ovf", ovf1, 1); chk("t3_rdy_hold", rdy1, 0); chk("t3_busy0", busy1, 0);
        cyc(); v1 = 1; p1 = 8'h01;
        @(negedge clk); chk("t3_rdy_c", rdy1, 1); chk("t3_valid_lo", ov1, 0);
        cyc(); cyc(); v1 = 0;
        @(negedge clk);
        chk("t3_valid2", ov1, 1); chk("t3_sum2", sum1, 8'h02); chk("t3_ovf2", ovf1, 0);
        cyc();

        // COUNT=1
        @(negedge clk); chk("t6_rdy0", rdy2, 1);
        cyc(); v2 = 1; p2 = 8'hA9;
        @(negedge clk); chk("t6_rdy1", rdy2, 1);
        cyc(); v2 = 0;
        @(negedge clk);
        chk("t6_valid", ov2, 1); chk("t6_sum", sum2, 16'h00A9);
        chk("t6_rdy2", rdy2, 0); chk("t6_busy", busy2, 0); chk("t6_ovf", ovf2, 0);
        cyc();
        @(negedge clk); chk("t6_rdy3", rdy2, 1); chk("t6_valid_lo", ov2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
